// File: rtl/sim_ram_dp.sv
// Simple dual-port RAM: one byte-masked write port and one pipelined read port with
// configurable latency, range checking and selectable read-first/write-first collisions.
module sim_ram_dp #(
    parameter int DP      = 512,
    parameter int DW      = 32,
    parameter int MW      = 4,
    parameter int AW      = 9,
    parameter int RD_LAT  = 1,
    parameter int RW_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [MW-1:0] wr_mask,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_err,
    output logic          rd_collide
);
    localparam int          IW   = (DP > 1) ? $clog2(DP) : 1;
    localparam logic [AW:0] DP_L = (AW + 1)'(DP);

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("sim_ram_dp: RD_LAT must lie in 1..3");
    end
    if (MW != (DW + 7) / 8) begin : g_bad_mw
        $error("sim_ram_dp: MW must equal ceil(DW/8)");
    end
    if ((64'd1 << AW) < 64'(DP)) begin : g_bad_aw
        $error("sim_ram_dp: AW too narrow for DP");
    end

    typedef struct packed {
        logic          valid;
        logic          err;
        logic          collide;
        logic [DW-1:0] data;
    } rd_stage_t;

    logic [DW-1:0] mem_q [DP];
    logic [DW-1:0] bit_en;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          wr_ok;
    logic          rd_ok;
    logic          rd_in_range;
    logic          collide;
    logic [DW-1:0] old_word;
    logic [DW-1:0] rd_word;
    rd_stage_t     pipe_q [RD_LAT];
    rd_stage_t     pipe_d [RD_LAT];

    // Expand lane enables to bits; a partial last byte shares the top lane enable.
    for (genvar g = 0; g < DW; g++) begin : g_lane
        localparam int LANE = (g / 8 < MW) ? g / 8 : MW - 1;
        assign bit_en[g] = wr_mask[LANE];
    end

    assign wr_idx      = wr_addr[IW-1:0];
    assign rd_idx      = rd_addr[IW-1:0];
    assign wr_ok       = wr_en && !rst && ({1'b0, wr_addr} < DP_L);
    assign rd_ok       = rd_en && !rst;
    assign rd_in_range = {1'b0, rd_addr} < DP_L;
    assign collide     = rd_ok && wr_en && rd_in_range && (rd_addr == wr_addr) && (|wr_mask);
    assign old_word    = mem_q[rd_idx];

    // NOTE: the storage array has no reset branch; a RAM macro cannot be cleared in one
    // cycle, so only the small read pipeline below is reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_idx] <= (wr_data & bit_en) | (mem_q[wr_idx] & ~bit_en);
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = old_word;
            if (collide && RW_MODE == 1) begin
                rd_word = (wr_data & bit_en) | (old_word & ~bit_en);
            end
        end
    end

    // NOTE: every stage starts from its held value so no path through this block can
    // leave a field unassigned and infer a latch.
    always_comb begin
        for (int s = 0; s < RD_LAT; s++) begin
            pipe_d[s] = pipe_q[s];
        end
        pipe_d[0].valid   = rd_ok;
        pipe_d[0].err     = rd_ok && !rd_in_range;
        pipe_d[0].collide = collide;
        if (rd_ok) begin
            pipe_d[0].data = rd_word;
        end
        for (int s = 1; s < RD_LAT; s++) begin
            pipe_d[s].valid   = pipe_q[s-1].valid;
            pipe_d[s].err     = pipe_q[s-1].err;
            pipe_d[s].collide = pipe_q[s-1].collide;
            if (pipe_q[s-1].valid) begin
                pipe_d[s].data = pipe_q[s-1].data;
            end
        end
    end

    // Data fields advance only behind a valid token, so the last stage holds the most
    // recently returned word while no result is emerging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
        end
    end

    assign rd_data    = pipe_q[RD_LAT-1].data;
    assign rd_valid   = pipe_q[RD_LAT-1].valid;
    assign rd_err     = pipe_q[RD_LAT-1].err;
    assign rd_collide = pipe_q[RD_LAT-1].collide;

endmodule
